instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Sits directly upstream of instruction_decoder.
- Holds a host-loaded instruction memory and a program counter (PC).
- Sequences one instruction chain from a start address, presenting each instruction word to the decoder over a valid/ready handshake.
- Stalls after every MV_MUL until the matrix-vector unit reports completion; halts on END_CHAIN.

Parameters:
- INSTR_WIDTH, 24, instruction word width: opcode[23:20], op1[19:10], op2[9:0]
- OPCODE_WIDTH, 4, opcode field width (MSBs of the word)
- IMEM_AWIDTH, 8, instruction memory address width; depth = 2**IMEM_AWIDTH

Ports:
- clk  in  1  single clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- imem_wr_en  in  1  host write strobe into instruction memory
- imem_wr_addr  in  IMEM_AWIDTH  host write address
- imem_wr_data  in  INSTR_WIDTH  host write data
- go  in  1  one-cycle pulse that starts a chain at start_pc
- start_pc  in  IMEM_AWIDTH  first instruction address, sampled with go
- instr_out  out  INSTR_WIDTH  instruction word presented to the decoder
- instr_valid  out  1  instr_out is valid
- instr_ready  in  1  decoder accepts instr_out this cycle
- mvm_done  in  1  one-cycle pulse: MV_MUL operation complete
- busy  out  1  a chain is in progress
- chain_done  out  1  one-cycle pulse when the chain ends
- chain_err  out  1  sticky flag: chain ran off the end of memory; cleared by go or reset
- pc  out  IMEM_AWIDTH  address of the current or last fetched instruction

Behaviour:
- Reset values: instr_out=0, instr_valid=0, busy=0, chain_done=0, chain_err=0, pc=0, state=IDLE. Memory contents are not cleared.
- Reset asserted in any state returns the block to IDLE next cycle. Any pending instruction is dropped without a handshake.
- Instruction memory: simple dual-port, synchronous read, 1-cycle latency.
  - Read-first: a same-cycle write to the address being read returns the old data.
  - Host writes are accepted in every state.
- States:
  - IDLE: busy=0. On go: pc<=start_pc, chain_err<=0, issue memory read of start_pc, go to FETCH. Without go: stay.
  - FETCH: busy=1. Memory data becomes available; register it into instr_out, set instr_valid=1, go to ISSUE.
  - ISSUE: instr_valid held high and instr_out held stable until instr_valid&&instr_ready. On that handshake instr_valid<=0, then the first matching rule applies:
    - opcode==END_CHAIN (12): chain_done pulses next cycle, go to IDLE.
    - pc==2**IMEM_AWIDTH-1: chain_err<=1, chain_done pulses, go to IDLE. No wrap to 0.
    - opcode==MV_MUL (4): go to WAIT_MVM.
    - otherwise: pc<=pc+1, read pc+1, go to FETCH.
  - WAIT_MVM: busy=1, instr_valid=0. On mvm_done: pc<=pc+1, read pc+1, go to FETCH.
- mvm_done is sampled only in WAIT_MVM. A pulse in any other state, including the MV_MUL handshake cycle itself, is ignored.
- go while busy is ignored.
- Throughput: 2 cycles minimum per instruction (FETCH + ISSUE with ready high).
- Latency: go at cycle 0 gives instr_valid=1 at cycle 2.
- Every opcode value other than MV_MUL and END_CHAIN, including unused values 13-15, is passed through unchanged with no special sequencing.
- chain_done is high for exactly one cycle per chain, in the cycle busy falls to 0.

Decomposition:
- Shared package: INSTR_WIDTH, OPCODE_WIDTH, VRF_AWIDTH, MRF_AWIDTH, MEM_ID_WIDTH and the opcode constants (V_RD..END_CHAIN). The decoder and this block both import it.
- State encoding is a localparam set inside this block.
- One sub-module: instr_mem, a simple dual-port synchronous-read RAM parameterised by width and depth, so it can map to a BRAM.

Test Plan:
- Load addr0=V_RD(0x0_001_005), addr1=VV_ADD(0x5_000_000), addr2=END_CHAIN(0xC_000_000); go with start_pc=0, instr_ready=1 -> three words issued in order at cycles 2, 4, 6; chain_done at cycle 7; busy low from cycle 7; chain_err=0.
- Program MV_MUL at addr0, END_CHAIN at addr1; mvm_done pulsed 10 cycles after the MV_MUL handshake -> instr_valid stays 0 throughout the wait; END_CHAIN is issued 2 cycles after mvm_done. Repeat with mvm_done pulsed in the handshake cycle itself -> the pulse is ignored and the block stays in WAIT_MVM.
- Hold instr_ready=0 for 5 cycles while instr_valid=1 -> instr_out stays stable and pc does not change; a single handshake occurs when ready rises.
- Fill 0..255 with VV_PASS (no END_CHAIN), go with start_pc=254 -> addresses 254 and 255 are issued, then chain_err=1 and chain_done pulses; no wrap to 0.
- Assert reset in WAIT_MVM and in ISSUE with instr_valid=1 -> next cycle instr_valid=0, busy=0, pc=0. A following go restarts cleanly from start_pc.
- Pulse go while busy=1 -> ignored, pc unaffected. Host write to the address being fetched in the same cycle -> the old word is issued.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared ISA definitions for the instruction fetch unit and the instruction decoder.
// Instruction word layout: opcode[23:20], op1[19:10], op2[9:0].
package instr_fetch_unit_pkg;

    localparam int unsigned INSTR_WIDTH  = 24;
    localparam int unsigned OPCODE_WIDTH = 4;
    localparam int unsigned VRF_AWIDTH   = 10;
    localparam int unsigned MRF_AWIDTH   = 10;
    localparam int unsigned MEM_ID_WIDTH = 2;
    localparam int unsigned IMEM_AWIDTH  = 8;

    typedef logic [OPCODE_WIDTH-1:0] opcode_t;

    localparam opcode_t V_RD      = 4'd0;
    localparam opcode_t V_WR      = 4'd1;
    localparam opcode_t M_RD      = 4'd2;
    localparam opcode_t M_WR      = 4'd3;
    localparam opcode_t MV_MUL    = 4'd4;
    localparam opcode_t VV_ADD    = 4'd5;
    localparam opcode_t VV_SUB    = 4'd6;
    localparam opcode_t VV_PASS   = 4'd7;
    localparam opcode_t VV_MUL    = 4'd8;
    localparam opcode_t V_RELU    = 4'd9;
    localparam opcode_t V_SIGM    = 4'd10;
    localparam opcode_t V_TANH    = 4'd11;
    localparam opcode_t END_CHAIN = 4'd12;

    function automatic opcode_t get_opcode(input logic [INSTR_WIDTH-1:0] word);
        return word[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Host, decoder and MVM-side signals of the fetch unit.
// master = fetch unit, slave = host/decoder/MVM side.
interface instr_fetch_unit_if #(
    parameter int unsigned INSTR_WIDTH = instr_fetch_unit_pkg::INSTR_WIDTH,
    parameter int unsigned IMEM_AWIDTH = instr_fetch_unit_pkg::IMEM_AWIDTH
) ();
    import instr_fetch_unit_pkg::*;

    logic                   imem_wr_en;
    logic [IMEM_AWIDTH-1:0] imem_wr_addr;
    logic [INSTR_WIDTH-1:0] imem_wr_data;
    logic                   go;
    logic [IMEM_AWIDTH-1:0] start_pc;
    logic [INSTR_WIDTH-1:0] instr_out;
    logic                   instr_valid;
    logic                   instr_ready;
    logic                   mvm_done;
    logic                   busy;
    logic                   chain_done;
    logic                   chain_err;
    logic [IMEM_AWIDTH-1:0] pc;

    modport master (
        input  imem_wr_en, imem_wr_addr, imem_wr_data,
        input  go, start_pc, instr_ready, mvm_done,
        output instr_out, instr_valid, busy, chain_done, chain_err, pc
    );

    modport slave (
        output imem_wr_en, imem_wr_addr, imem_wr_data,
        output go, start_pc, instr_ready, mvm_done,
        input  instr_out, instr_valid, busy, chain_done, chain_err, pc
    );

endinterface

// File: rtl/instr_fetch_unit_mem.sv
// Simple dual-port RAM, synchronous read with 1-cycle latency, read-first on
// address collision. No reset so it can map onto block RAM.
module instr_mem #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AWIDTH = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: walks one instruction chain out of a host-loaded
// memory, handing each word to the decoder and pausing after MV_MUL.
module instr_fetch_unit #(
    parameter int unsigned INSTR_WIDTH  = instr_fetch_unit_pkg::INSTR_WIDTH,
    parameter int unsigned OPCODE_WIDTH = instr_fetch_unit_pkg::OPCODE_WIDTH,
    parameter int unsigned IMEM_AWIDTH  = instr_fetch_unit_pkg::IMEM_AWIDTH
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_unit_if.master bus
);
    import instr_fetch_unit_pkg::*;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_FETCH    = 2'd1;
    localparam logic [1:0] S_ISSUE    = 2'd2;
    localparam logic [1:0] S_WAIT_MVM = 2'd3;

    logic [1:0]              state;
    logic [INSTR_WIDTH-1:0]  instr_q;
    logic                    valid_q;
    logic                    done_q;
    logic                    err_q;
    logic [IMEM_AWIDTH-1:0]  pc_q;
    logic [IMEM_AWIDTH-1:0]  pc_next;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic                    handshake;
    logic                    is_end;
    logic                    is_last;
    logic                    is_mvm;
    logic                    rd_en;
    logic [IMEM_AWIDTH-1:0]  rd_addr;
    logic [INSTR_WIDTH-1:0]  rd_data;

    assign pc_next   = pc_q + 1'b1;
    assign opcode    = instr_q[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    assign handshake = (state == S_ISSUE) && valid_q && bus.instr_ready;
    assign is_end    = (opcode == END_CHAIN);
    assign is_last   = (pc_q == '1);
    assign is_mvm    = (opcode == MV_MUL);

    // Reads are launched on the transition into FETCH so the word is ready there.
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = pc_next;
        case (state)
            S_IDLE: begin
                rd_en   = bus.go;
                rd_addr = bus.start_pc;
            end
            S_ISSUE:    rd_en = handshake && !is_end && !is_last && !is_mvm;
            S_WAIT_MVM: rd_en = bus.mvm_done;
            default:    rd_en = 1'b0;
        endcase
    end

    instr_mem #(
        .WIDTH (INSTR_WIDTH),
        .DEPTH (2 ** IMEM_AWIDTH),
        .AWIDTH(IMEM_AWIDTH)
    ) u_mem (
        .clk    (clk),
        .wr_en  (bus.imem_wr_en),
        .wr_addr(bus.imem_wr_addr),
        .wr_data(bus.imem_wr_data),
        .rd_en  (rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            instr_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            pc_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.go) begin
                        pc_q  <= bus.start_pc;
                        err_q <= 1'b0;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    instr_q <= rd_data;
                    valid_q <= 1'b1;
                    state   <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (handshake) begin
                        valid_q <= 1'b0;
                        if (is_end) begin
                            done_q <= 1'b1;
                            state  <= S_IDLE;
                        end else if (is_last) begin
                            err_q  <= 1'b1;
                            done_q <= 1'b1;
                            state  <= S_IDLE;
                        end else if (is_mvm) begin
                            state <= S_WAIT_MVM;
                        end else begin
                            pc_q  <= pc_next;
                            state <= S_FETCH;
                        end
                    end
                end
                S_WAIT_MVM: begin
                    if (bus.mvm_done) begin
                        pc_q  <= pc_next;
                        state <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.instr_out   = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.busy        = (state != S_IDLE);
    assign bus.chain_done  = done_q;
    assign bus.chain_err   = err_q;
    assign bus.pc          = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit: chain sequencing, MV_MUL
// stall, decoder back-pressure, end-of-memory error, reset and collisions.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(
        .INSTR_WIDTH (24),
        .OPCODE_WIDTH(4),
        .IMEM_AWIDTH (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    function automatic logic [23:0] mk(input int op, input int a, input int b);
        logic [23:0] w;
        w = {op[3:0], a[9:0], b[9:0]};
        return w;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mem(input int addr, input logic [23:0] data);
        bus.imem_wr_en   = 1'b1;
        bus.imem_wr_addr = addr[7:0];
        bus.imem_wr_data = data;
        tick();
        bus.imem_wr_en   = 1'b0;
    endtask

    // Pulses go in the current cycle; returns in cycle 1 of the chain.
    task automatic start(input int addr);
        bus.go       = 1'b1;
        bus.start_pc = addr[7:0];
        tick();
        bus.go       = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!bus.chain_done && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, {31'd0, bus.chain_done}, 32'd1);
    endtask

    initial begin
        bus.imem_wr_en   = 1'b0;
        bus.imem_wr_addr = '0;
        bus.imem_wr_data = '0;
        bus.go           = 1'b0;
        bus.start_pc     = '0;
        bus.instr_ready  = 1'b1;
        bus.mvm_done     = 1'b0;
        tick();
        tick();
        check_eq("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        check_eq("rst_busy",  {31'd0, bus.busy}, 32'd0);
        check_eq("rst_done",  {31'd0, bus.chain_done}, 32'd0);
        check_eq("rst_err",   {31'd0, bus.chain_err}, 32'd0);
        check_eq("rst_pc",    {24'd0, bus.pc}, 32'd0);
        check_eq("rst_out",   {8'd0, bus.instr_out}, 32'd0);
        reset = 1'b0;

        // Three-word chain with ready held high
        write_mem(0, mk(0, 1, 5));
        write_mem(1, mk(5, 0, 0));
        write_mem(2, mk(12, 0, 0));
        start(0);
        check_eq("c1_busy", {31'd0, bus.busy}, 32'd1);
        check_eq("c1_valid", {31'd0, bus.instr_valid}, 32'd0);
        tick();
        check_eq("c2_valid", {31'd0, bus.instr_valid}, 32'd1);
        check_eq("c2_out", {8'd0, bus.instr_out}, {8'd0, mk(0, 1, 5)});
        check_eq("c2_pc", {24'd0, bus.pc}, 32'd0);
        tick();
        check_eq("c3_valid", {31'd0, bus.instr_valid}, 32'd0);
        tick();
        check_eq("c4_out", {8'd0, bus.instr_out}, {8'd0, mk(5, 0, 0)});
        check_eq("c4_pc", {24'd0, bus.pc}, 32'd1);
        tick();
        tick();
        check_eq("c6_valid", {31'd0, bus.instr_valid}, 32'd1);
        check_eq("c6_out", {8'd0, bus.instr_out}, {8'd0, mk(12, 0, 0)});
        tick();
        check_eq("c7_done", {31'd0, bus.chain_done}, 32'd1);
        check_eq("c7_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("c7_err", {31'd0, bus.chain_err}, 32'd0);
        tick();
        check_eq("c8_done", {31'd0, bus.chain_done}, 32'd0);

        // MV_MUL stall, mvm_done 10 cycles after the handshake
        write_mem(0, mk(4, 3, 7));
        write_mem(1, mk(12, 0, 0));
        start(0);
        tick();
        check_eq("mv_out", {8'd0, bus.instr_out}, {8'd0, mk(4, 3, 7)});
        for (int c = 3; c < 12; c++) begin
            tick();
            check_eq("mv_wait_valid", {31'd0, bus.instr_valid}, 32'd0);
        end
        check_eq("mv_wait_busy", {31'd0, bus.busy}, 32'd1);
        tick();
        bus.mvm_done = 1'b1;
        tick();
        bus.mvm_done = 1'b0;
        check_eq("mv_c13_valid", {31'd0, bus.instr_valid}, 32'd0);
        tick();
        check_eq("mv_c14_valid", {31'd0, bus.instr_valid}, 32'd1);
        check_eq("mv_c14_out", {8'd0, bus.instr_out}, {8'd0, mk(12, 0, 0)});
        check_eq("mv_c14_pc", {24'd0, bus.pc}, 32'd1);
        tick();
        check_eq("mv_done", {31'd0, bus.chain_done}, 32'd1);

        // mvm_done in the MV_MUL handshake cycle must be ignored
        start(0);
        tick();
        bus.mvm_done = 1'b1;
        tick();
        bus.mvm_done = 1'b0;
        tick();
        tick();
        tick();
        check_eq("mvx_valid", {31'd0, bus.instr_valid}, 32'd0);
        check_eq("mvx_busy", {31'd0, bus.busy}, 32'd1);
        check_eq("mvx_pc", {24'd0, bus.pc}, 32'd0);
        bus.mvm_done = 1'b1;
        tick();
        bus.mvm_done = 1'b0;
        wait_done("mvx_finish", 20);

        // Decoder back-pressure
        write_mem(0, mk(0, 1, 5));
        write_mem(1, mk(5, 0, 0));
        write_mem(2, mk(12, 0, 0));
        bus.instr_ready = 1'b0;
        start(0);
        tick();
        for (int c = 0; c < 5; c++) begin
            check_eq("bp_valid", {31'd0, bus.instr_valid}, 32'd1);
            check_eq("bp_out", {8'd0, bus.instr_out}, {8'd0, mk(0, 1, 5)});
            check_eq("bp_pc", {24'd0, bus.pc}, 32'd0);
            tick();
        end
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        check_eq("bp_hs_valid", {31'd0, bus.instr_valid}, 32'd0);
        check_eq("bp_hs_pc", {24'd0, bus.pc}, 32'd1);
        tick();
        check_eq("bp_next_out", {8'd0, bus.instr_out}, {8'd0, mk(5, 0, 0)});
        check_eq("bp_next_pc", {24'd0, bus.pc}, 32'd1);
        bus.instr_ready = 1'b1;
        wait_done("bp_finish", 20);
        tick();

        // Run off the end of memory
        for (int a = 0; a < 256; a++) write_mem(a, mk(7, a, a));
        start(254);
        tick();
        check_eq("eom_pc254", {24'd0, bus.pc}, 32'd254);
        check_eq("eom_out254", {8'd0, bus.instr_out}, {8'd0, mk(7, 254, 254)});
        tick();
        tick();
        check_eq("eom_pc255", {24'd0, bus.pc}, 32'd255);
        check_eq("eom_out255", {8'd0, bus.instr_out}, {8'd0, mk(7, 255, 255)});
        tick();
        check_eq("eom_done", {31'd0, bus.chain_done}, 32'd1);
        check_eq("eom_err", {31'd0, bus.chain_err}, 32'd1);
        check_eq("eom_busy", {31'd0, bus.busy}, 32'd0);
        tick();
        check_eq("eom_err_sticky", {31'd0, bus.chain_err}, 32'd1);
        check_eq("eom_nowrap_valid", {31'd0, bus.instr_valid}, 32'd0);
        check_eq("eom_nowrap_pc", {24'd0, bus.pc}, 32'd255);

        // Reset during WAIT_MVM, then during ISSUE with valid high
        write_mem(10, mk(4, 1, 1));
        write_mem(11, mk(12, 0, 0));
        start(10);
        check_eq("go_clears_err", {31'd0, bus.chain_err}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("rw_valid", {31'd0, bus.instr_valid}, 32'd0);
        check_eq("rw_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("rw_pc", {24'd0, bus.pc}, 32'd0);
        bus.instr_ready = 1'b0;
        start(10);
        tick();
        check_eq("ri_valid_pre", {31'd0, bus.instr_valid}, 32'd1);
        check_eq("ri_pc_pre", {24'd0, bus.pc}, 32'd10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.instr_ready = 1'b1;
        check_eq("ri_valid", {31'd0, bus.instr_valid}, 32'd0);
        check_eq("ri_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("ri_pc", {24'd0, bus.pc}, 32'd0);
        start(11);
        tick();
        check_eq("rs_out", {8'd0, bus.instr_out}, {8'd0, mk(12, 0, 0)});
        check_eq("rs_pc", {24'd0, bus.pc}, 32'd11);
        tick();
        check_eq("rs_done", {31'd0, bus.chain_done}, 32'd1);

        // go while busy is ignored
        start(10);
        tick();
        tick();
        bus.go = 1'b1;
        bus.start_pc = 8'd50;
        tick();
        bus.go = 1'b0;
        check_eq("gb_pc", {24'd0, bus.pc}, 32'd10);
        check_eq("gb_busy", {31'd0, bus.busy}, 32'd1);
        bus.mvm_done = 1'b1;
        tick();
        bus.mvm_done = 1'b0;
        wait_done("gb_finish", 20);
        check_eq("gb_last_pc", {24'd0, bus.pc}, 32'd11);

        // Host write colliding with the launch read returns the old word
        bus.go           = 1'b1;
        bus.start_pc     = 8'd20;
        bus.imem_wr_en   = 1'b1;
        bus.imem_wr_addr = 8'd20;
        bus.imem_wr_data = mk(12, 0, 0);
        tick();
        bus.go         = 1'b0;
        bus.imem_wr_en = 1'b0;
        tick();
        check_eq("col_old", {8'd0, bus.instr_out}, {8'd0, mk(7, 20, 20)});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start(20);
        tick();
        check_eq("col_new", {8'd0, bus.instr_out}, {8'd0, mk(12, 0, 0)});
        wait_done("col_finish", 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
